// File: rtl/mcu_rd_pkg.sv
// Shared types and defaults for the MCU read-port slice.
// MCU_RD_CHECKSUM_EN adds the trailing XOR checksum byte.
package mcu_rd_pkg;

  localparam int MCU_RD_SYNC_STAGES = 2;
  localparam int MCU_RD_ADDR_W      = 13;
  localparam int MCU_RD_FRAME_LEN   = 8192;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LATCH,
    ST_READY,
`ifdef MCU_RD_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } mcu_rd_state_t;

endpackage

// File: rtl/mcu_read_port_if.sv
// MCU read-side pins plus the sample RAM read port.
// master is the MCU/RAM side, slave is mcu_read_port.
interface mcu_read_port_if #(
  parameter int ADDR_W = 13
);

  logic              oe;
  logic              rd_start;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic [7:0]        mcu_data_out;
  logic              mcu_data_oe;
  logic              busy;
  logic              overrun;

  modport master (
    output oe, rd_start, ram_data,
    input  ram_addr, mcu_data_out,
    input  mcu_data_oe, busy, overrun
  );

  modport slave (
    input  oe, rd_start, ram_data,
    output ram_addr, mcu_data_out,
    output mcu_data_oe, busy, overrun
  );

endinterface

// File: rtl/edge_sync.sv
// Multi-flop synchronizer with one-cycle rise/fall pulses.
// Pulses are derived from the synchronized level only.
module edge_sync
  import mcu_rd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [MCU_RD_SYNC_STAGES-1:0] sync;
  logic                          prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[MCU_RD_SYNC_STAGES-2:0], din};
      prev <= sync[MCU_RD_SYNC_STAGES-1];
    end
  end

  assign level = sync[MCU_RD_SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/mcu_read_port.sv
// Returns one sample byte per MCU read strobe, auto-incrementing.
// MCU_RD_CHECKSUM_EN appends an XOR checksum read to each frame.
module mcu_read_port
  import mcu_rd_pkg::*;
#(
  parameter int ADDR_W    = MCU_RD_ADDR_W,
  parameter int FRAME_LEN = MCU_RD_FRAME_LEN
) (
  input  logic         clk,
  input  logic         rst,
  mcu_read_port_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

  mcu_rd_state_t     state;
  mcu_rd_state_t     state_d;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dout;
  logic              oe_q;
  logic              ovr;

  logic oe_lvl, oe_rise, oe_fall;
  logic st_lvl, st_rise, st_fall;
  logic restart, ld_addr, ld_data, inc_ptr;
  logic unused_st;

`ifdef MCU_RD_CHECKSUM_EN
  logic [7:0] csum;
  logic       ld_csum;
`endif

  edge_sync u_oe_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.oe),
    .level (oe_lvl),
    .rise  (oe_rise),
    .fall  (oe_fall)
  );

  edge_sync u_st_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.rd_start),
    .level (st_lvl),
    .rise  (st_rise),
    .fall  (st_fall)
  );

  assign unused_st = st_lvl ^ st_fall;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  // A start request beats any same-cycle strobe edge.
  always_comb begin
    state_d = state;
    restart = 1'b0;
    ld_addr = 1'b0;
    ld_data = 1'b0;
    inc_ptr = 1'b0;
`ifdef MCU_RD_CHECKSUM_EN
    ld_csum = 1'b0;
`endif
    if (st_rise) begin
      restart = 1'b1;
      state_d = ST_ADDR;
    end else begin
      unique case (state)
        ST_ADDR: begin
          ld_addr = 1'b1;
          state_d = ST_LATCH;
        end
        ST_LATCH: begin
          ld_data = 1'b1;
          state_d = ST_READY;
        end
        ST_READY: begin
          if (oe_rise) begin
            if (ptr == LAST) begin
`ifdef MCU_RD_CHECKSUM_EN
              ld_csum = 1'b1;
              state_d = ST_CSUM;
`else
              state_d = ST_DONE;
`endif
            end else begin
              inc_ptr = 1'b1;
              state_d = ST_ADDR;
            end
          end
        end
`ifdef MCU_RD_CHECKSUM_EN
        ST_CSUM: begin
          if (oe_rise) state_d = ST_DONE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr    <= '0;
      addr_q <= '0;
      dout   <= '0;
      oe_q   <= 1'b0;
      ovr    <= 1'b0;
`ifdef MCU_RD_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      oe_q <= ~oe_lvl & (state_d != ST_IDLE);
      if (restart) begin
        ptr <= '0;
        ovr <= 1'b0;
`ifdef MCU_RD_CHECKSUM_EN
        csum <= '0;
`endif
      end else begin
        if (inc_ptr) ptr <= ptr + ADDR_W'(1);
        if (oe_fall && (state == ST_ADDR || state == ST_LATCH))
          ovr <= 1'b1;
      end
      if (ld_addr) addr_q <= ptr;
      if (ld_data) begin
        dout <= bus.ram_data;
`ifdef MCU_RD_CHECKSUM_EN
        csum <= csum ^ bus.ram_data;
`endif
      end
`ifdef MCU_RD_CHECKSUM_EN
      if (ld_csum) dout <= csum;
`endif
    end
  end

  assign bus.ram_addr     = addr_q;
  assign bus.mcu_data_out = dout;
  assign bus.mcu_data_oe  = oe_q;
  assign bus.overrun      = ovr;
  assign bus.busy         = (state != ST_IDLE) && (state != ST_DONE);

endmodule
